// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in serial-out transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package piso_pkg;

    // Default word width when the parent does not override it.
    localparam int PISO_WIDTH_DEF = 4;

    // Transmitter FSM encoding. PARITY is only reachable in parity builds.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

endpackage : piso_pkg

// File: rtl/piso_bit_counter.sv
// Bit-index counter for one frame; flags the last data bit (count == WIDTH-1).
// Latency: count updates on the clock edge; terminal flag is combinational from the count.
// Backpressure: none; saturates at WIDTH-1 rather than wrapping past the frame.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);

    // Clear wins over enable; holding at LAST keeps the index inside the frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !w_at_last) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_tc = w_at_last;

endmodule : piso_bit_counter

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter; optional even-parity trailer bit under PISO_PARITY_EN.
// Latency: first bit appears registered at the accept edge (0 cycles); frame is WIDTH (+1 parity) cycles.
// Backpressure: load_ready high in IDLE and in the final bit cycle of a frame, allowing gapless frames.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_WIDTH_DEF,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_shift;
    logic             r_sout;
    logic             r_svld;
    logic             r_fstart;

    logic             w_tc;
    logic             w_accept;
    logic             w_load_ready;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_shift_nxt;

`ifdef PISO_PARITY_EN
    logic             r_parity;
`endif

    // Bit position counter inside the current frame.
    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_tc    (w_tc)
    );

    // Bit selection depends only on transmit order: the first bit comes straight
    // from the incoming word, later bits from the neighbour of the current bit.
    assign w_first_bit = LSB_FIRST ? data[0]    : data[WIDTH-1];
    assign w_next_bit  = LSB_FIRST ? r_shift[1] : r_shift[WIDTH-2];
    assign w_shift_nxt = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, handshake and counter control; a new accept overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_ready = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_load_ready = 1'b1;
            end
            ST_SHIFT: begin
                if (w_tc) begin
                    w_cnt_clr = 1'b1;
`ifdef PISO_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    w_load_ready = 1'b1;
                    w_state_nxt  = ST_IDLE;
`endif
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                w_load_ready = 1'b1;
                w_cnt_clr    = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
`endif
            default: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Never advertise readiness while held in reset.
        w_load_ready = w_load_ready & reset;
        w_accept     = load_valid & w_load_ready;

        if (w_accept) begin
            w_state_nxt = ST_SHIFT;
            w_cnt_clr   = 1'b1;
            w_cnt_en    = 1'b0;
        end
    end

    // Shift register and registered serial outputs; idle drives zeros.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shift  <= '0;
            r_sout   <= 1'b0;
            r_svld   <= 1'b0;
            r_fstart <= 1'b0;
        end else if (w_accept) begin
            r_shift  <= data;
            r_sout   <= w_first_bit;
            r_svld   <= 1'b1;
            r_fstart <= 1'b1;
        end else if (r_state == ST_SHIFT && !w_tc) begin
            r_shift  <= w_shift_nxt;
            r_sout   <= w_next_bit;
            r_fstart <= 1'b0;
`ifdef PISO_PARITY_EN
        end else if (r_state == ST_SHIFT) begin
            // Last data bit done: trailer carries the parity captured at accept.
            r_shift  <= '0;
            r_sout   <= r_parity;
            r_fstart <= 1'b0;
`endif
        end else begin
            r_shift  <= '0;
            r_sout   <= 1'b0;
            r_svld   <= 1'b0;
            r_fstart <= 1'b0;
        end
    end

`ifdef PISO_PARITY_EN
    // Even parity of the accepted word, held until the trailer bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^data;
        end
    end
`endif

    assign load_ready   = w_load_ready;
    assign serial_out   = r_sout;
    assign serial_valid = r_svld;
    assign frame_start  = r_fstart;
    assign busy         = (r_state != ST_IDLE);

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Self-checking bench: LSB-first and MSB-first instances share stimulus and are scored per cycle.
// Latency: reference queue holds one entry per expected output cycle, front = current cycle.
// Backpressure: expected load_ready derives from the number of frame bits still pending.
module tb_piso_serializer;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clock;
    logic         reset;
    logic         load_valid;
    logic [W-1:0] data;

    logic rdy_l, out_l, vld_l, fs_l, busy_l;
    logic rdy_m, out_m, vld_m, fs_m, busy_m;

    int n_checks;
    int n_fail;

    typedef struct packed {
        logic b_lsb;
        logic b_msb;
        logic fs;
    } exp_t;

    exp_t q[$];

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_dut_lsb (
        .clock        (clock),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (rdy_l),
        .data         (data),
        .serial_out   (out_l),
        .serial_valid (vld_l),
        .frame_start  (fs_l),
        .busy         (busy_l)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_dut_msb (
        .clock        (clock),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (rdy_m),
        .data         (data),
        .serial_out   (out_m),
        .serial_valid (vld_m),
        .frame_start  (fs_m),
        .busy         (busy_m)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    // Expected output stream for one word: data bits in both orders, then optional parity.
    task automatic push_word(input logic [W-1:0] w);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.b_lsb = w[i];
            e.b_msb = w[W-1-i];
            e.fs    = (i == 0);
            q.push_back(e);
        end
        if (PAR) begin
            e.b_lsb = ^w;
            e.b_msb = ^w;
            e.fs    = 1'b0;
            q.push_back(e);
        end
    endtask

    // One clock cycle: drive, score at the falling edge, advance the model at the rising edge.
    task automatic run_cycle(input logic lv, input logic [W-1:0] d);
        logic act;
        logic exp_rdy;
        exp_t e;
        load_valid = lv;
        data       = d;
        @(negedge clock);
        act     = (q.size() > 0);
        exp_rdy = reset && (q.size() <= 1);
        e       = act ? q[0] : '0;
        check("lsb_out",   out_l,  e.b_lsb);
        check("lsb_valid", vld_l,  act);
        check("lsb_start", fs_l,   e.fs);
        check("lsb_busy",  busy_l, act);
        check("lsb_ready", rdy_l,  exp_rdy);
        check("msb_out",   out_m,  e.b_msb);
        check("msb_valid", vld_m,  act);
        check("msb_start", fs_m,   e.fs);
        check("msb_ready", rdy_m,  exp_rdy);
        @(posedge clock);
        if (q.size() > 0) void'(q.pop_front());
        if (lv && exp_rdy) push_word(d);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, '0);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must drop at once.
    task automatic reset_pulse();
        #2;
        reset      = 1'b0;
        load_valid = 1'b1;
        #1;
        check("rst_out",   out_l | out_m,  1'b0);
        check("rst_valid", vld_l | vld_m,  1'b0);
        check("rst_start", fs_l | fs_m,    1'b0);
        check("rst_busy",  busy_l | busy_m, 1'b0);
        check("rst_ready", rdy_l | rdy_m,  1'b0);
        q.delete();
        @(posedge clock);
        #1;
        check("rst_hold_ready", rdy_l, 1'b0);
        check("rst_hold_valid", vld_l, 1'b0);
        reset      = 1'b1;
        load_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] w;
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        load_valid = 1'b0;
        data       = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_out",   out_l,  1'b0);
        check("reset_valid", vld_l,  1'b0);
        check("reset_start", fs_l,   1'b0);
        check("reset_busy",  busy_l, 1'b0);
        check("reset_ready", rdy_l,  1'b0);
        reset = 1'b1;

        // Single frame in both bit orders.
        run_cycle(1'b1, 4'b1011);
        idle_cycles(W + 2);

        // Valid held high: second word accepted in the last bit cycle.
        run_cycle(1'b1, 4'b1011);
        for (int i = 0; i < W + int'(PAR); i++) run_cycle(1'b1, 4'b0100);
        idle_cycles(W + 2);

        // Load request during bit 1 must be ignored.
        run_cycle(1'b1, 4'b0000);
        run_cycle(1'b0, 4'b0000);
        run_cycle(1'b1, 4'b1111);
        idle_cycles(W + 2);

        // Reset mid-frame, then a clean idle period.
        run_cycle(1'b1, 4'b1011);
        run_cycle(1'b0, 4'b0000);
        run_cycle(1'b0, 4'b0000);
        reset_pulse();
        idle_cycles(3);

        // Parity-distinguishing words (plain frames when parity is not built in).
        run_cycle(1'b1, 4'b1011);
        idle_cycles(W + 2);
        run_cycle(1'b1, 4'b1001);
        idle_cycles(W + 2);

        // Random traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            w = W'($urandom);
            if (c == 200 || c == 417) reset_pulse();
            run_cycle($urandom_range(0, 3) != 0, w);
        end
        idle_cycles(W + 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_piso_serializer
